// File: rtl/grant_decoder_pkg.sv
// rtl/grant_decoder_pkg.sv - shared state encoding and default sizing for grant_decoder
package grant_decoder_pkg;

  localparam int DEFAULT_USER_WIDTH = 2;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic int n_users(input int user_width);
    return 2 ** user_width;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - registered one-hot grant held until the owner releases its request
// Optional forced release after MAX_HOLD cycles: define GRANT_DECODER_TIMEOUT_EN.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int USER_WIDTH = DEFAULT_USER_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter int MAX_HOLD   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [USER_WIDTH-1:0]      user,
  input  logic [2**USER_WIDTH-1:0]   request,
  output logic [2**USER_WIDTH-1:0]   grant,
  output logic                       busy,
  output logic [USER_WIDTH-1:0]      owner,
  output logic [CNT_WIDTH-1:0]       hold_cycles,
  output logic                       timeout
);

  localparam int N_USERS = n_users(USER_WIDTH);

  if (MAX_HOLD < 1 || MAX_HOLD > 2 ** CNT_WIDTH - 1) begin : g_bad_max_hold
    $error("grant_decoder: MAX_HOLD out of range for CNT_WIDTH");
  end

  function automatic logic [N_USERS-1:0] onehot(input logic [USER_WIDTH-1:0] idx);
    logic [N_USERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t                state, state_next;
  logic [N_USERS-1:0]    grant_next;
  logic [USER_WIDTH-1:0] owner_next;
  logic [CNT_WIDTH-1:0]  hold_next;
  logic                  owner_req;

  assign owner_req = request[owner];

`ifdef GRANT_DECODER_TIMEOUT_EN
  logic timeout_next;
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      hold_cycles <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      busy        <= (state_next != IDLE);
      owner       <= owner_next;
      hold_cycles <= hold_next;
    end
  end

`ifdef GRANT_DECODER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_next;
  end
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    owner_next = owner;
    hold_next  = hold_cycles;
`ifdef GRANT_DECODER_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        grant_next = '0;
        if (valid) begin
          owner_next = user;
          grant_next = onehot(user);
          hold_next  = '0;
          state_next = GRANTED;
        end
      end
      GRANTED: begin
        // Owner release takes precedence so a drop on the limit cycle is not a timeout.
        if (!owner_req) begin
          grant_next = '0;
          state_next = RELEASE;
        end
`ifdef GRANT_DECODER_TIMEOUT_EN
        else if (hold_cycles == CNT_WIDTH'(MAX_HOLD - 1)) begin
          grant_next   = '0;
          state_next   = RELEASE;
          timeout_next = 1'b1;
        end
`endif
        else if (hold_cycles != '1) begin
          hold_next = hold_cycles + 1'b1;
        end
      end
      RELEASE: begin
        grant_next = '0;
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_grant_decoder.sv
// tb/tb_grant_decoder.sv - directed self-checking bench for grant_decoder
// Timeout steps are exercised when GRANT_DECODER_TIMEOUT_EN is defined.
module tb_grant_decoder;

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 16;
`endif

  logic       clock;
  logic       reset;
  logic       valid;
  logic [1:0] user;
  logic [3:0] request;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] owner;
  logic [7:0] hold_cycles;
  logic       timeout;

  int compared;
  int mismatched;

  grant_decoder #(
    .USER_WIDTH(2),
    .CNT_WIDTH (8),
    .MAX_HOLD  (TB_MAX_HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .user       (user),
    .request    (request),
    .grant      (grant),
    .busy       (busy),
    .owner      (owner),
    .hold_cycles(hold_cycles),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [1:0] o, input logic [7:0] h, input logic t);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".hold"}, 32'(hold_cycles), 32'(h));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    valid      = 1'b0;
    user       = 2'd0;
    request    = 4'b0000;

    // Reset then idle
    tick();
    tick();
    chk_all("reset", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("idle", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);

    // Basic grant to user 2
    request = 4'b0100; valid = 1'b1; user = 2'd2;
    tick();
    chk_all("grant2", 4'b0100, 1'b1, 2'd2, 8'd0, 1'b0);

    // Other requests and a new selection are ignored while held
    request = 4'b0101; valid = 1'b1; user = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("hold2", 4'b0100, 1'b1, 2'd2, 8'(i), 1'b0);
    end

    // Owner drops: one RELEASE cycle, valid ignored there, hold frozen
    request = 4'b0000; valid = 1'b1; user = 2'd1;
    tick();
    chk_all("release2", 4'b0000, 1'b1, 2'd2, 8'd3, 1'b0);
    tick();
    chk_all("idle_after_rel", 4'b0000, 1'b0, 2'd2, 8'd3, 1'b0);

    // Grant to a requester whose bit is already low: one GRANTED cycle
    tick();
    chk_all("grant1_low", 4'b0010, 1'b1, 2'd1, 8'd0, 1'b0);
    valid = 1'b0;
    tick();
    chk_all("release1_low", 4'b0000, 1'b1, 2'd1, 8'd0, 1'b0);
    tick();
    chk_all("idle1", 4'b0000, 1'b0, 2'd1, 8'd0, 1'b0);

    // Back-to-back: user 0 then user 1 with a release gap
    request = 4'b0011; valid = 1'b1; user = 2'd0;
    tick();
    chk_all("b2b_grant0", 4'b0001, 1'b1, 2'd0, 8'd0, 1'b0);
    request = 4'b0010; valid = 1'b1; user = 2'd1;
    tick();
    chk_all("b2b_release", 4'b0000, 1'b1, 2'd0, 8'd0, 1'b0);
    tick();
    chk_all("b2b_idle", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    tick();
    chk_all("b2b_grant1", 4'b0010, 1'b1, 2'd1, 8'd0, 1'b0);
    request = 4'b0000; valid = 1'b0;
    tick();
    chk_all("b2b_rel1", 4'b0000, 1'b1, 2'd1, 8'd0, 1'b0);
    tick();

    // Mid-grant reset, then regrant once reset drops
    request = 4'b1000; valid = 1'b1; user = 2'd3;
    tick();
    chk_all("grant3", 4'b1000, 1'b1, 2'd3, 8'd0, 1'b0);
    tick();
    chk_all("hold3", 4'b1000, 1'b1, 2'd3, 8'd1, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("midreset", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("regrant3", 4'b1000, 1'b1, 2'd3, 8'd0, 1'b0);

`ifndef GRANT_DECODER_TIMEOUT_EN
    // Long hold saturates the counter and never forces release
    valid = 1'b0;
    repeat (300) tick();
    chk_all("saturate", 4'b1000, 1'b1, 2'd3, 8'd255, 1'b0);
`endif
    request = 4'b0000; valid = 1'b0;
    tick();
    chk("rel3.grant", 32'(grant), 32'h0);
    chk("rel3.busy", 32'(busy), 32'h1);
    tick();
    chk("idle3.busy", 32'(busy), 32'h0);

`ifdef GRANT_DECODER_TIMEOUT_EN
    // Forced release after exactly 4 grant cycles, then regrant
    request = 4'b0001; valid = 1'b1; user = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("to_hold", 4'b0001, 1'b1, 2'd0, 8'(i), 1'b0);
    end
    tick();
    chk_all("to_pulse", 4'b0000, 1'b1, 2'd0, 8'd3, 1'b1);
    tick();
    chk_all("to_idle", 4'b0000, 1'b0, 2'd0, 8'd3, 1'b0);
    tick();
    chk_all("to_regrant", 4'b0001, 1'b1, 2'd0, 8'd0, 1'b0);
    // Owner drops on the limit cycle: normal release, no timeout
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_all("to2_hold", 4'b0001, 1'b1, 2'd0, 8'(i), 1'b0);
    end
    request = 4'b0000; valid = 1'b0;
    tick();
    chk_all("to2_release", 4'b0000, 1'b1, 2'd0, 8'd3, 1'b0);
    tick();
    chk_all("to2_idle", 4'b0000, 1'b0, 2'd0, 8'd3, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
